// File: rtl/sequencer_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle stage sequencer.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

package sequencer_pkg;

  localparam int OPCODE_W = 11;

  typedef logic [`WORD-1:0]      word_t;
  typedef logic [`INSTR_LEN-1:0] instr_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_t;

  // Opcode classes as iDecode presents them (short opcodes left-aligned, zero-filled).
  typedef enum logic [OPCODE_W-1:0] {
    OPC_HALT = 11'b00000000000,
    OPC_B    = 11'b00010100000,
    OPC_CBZ  = 11'b10110100000,
    OPC_ADD  = 11'b10001011000,
    OPC_SUB  = 11'b11001011000,
    OPC_STUR = 11'b11111000000,
    OPC_LDUR = 11'b11111000010
  } opcode_class_t;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEFAULT = OPC_HALT;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic branch;
    logic uncondbranch;
  } ctrl_t;

  function automatic logic [OPCODE_W-1:0] instr_opcode(input instr_t instr);
    return instr[`INSTR_LEN-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Saturating retired-instruction counter with synchronous clear and a
// look-ahead flag telling whether the next increment lands on LIMIT.
module retire_counter #(
  parameter int          CNT_W = 32,
  parameter int unsigned LIMIT = 0
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_limit_hit
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (&val) ? val : val + ONE;
  endfunction

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_next;

  assign w_next      = sat_inc(r_count);
  assign o_limit_hit = (LIMIT != 0) && (w_next == CNT_W'(LIMIT));
  assign o_count     = r_count;

  always_ff @(posedge clk) begin
    if (i_clr)     r_count <= '0;
    else if (i_en) r_count <= w_next;
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer issuing one-cycle
// enable strobes to the LEGv8 datapath, with stall, memory wait and halt.
module stage_sequencer
  import sequencer_pkg::*;
#(
  parameter int                  CNT_W       = 32,
  parameter int unsigned         MAX_INSTR   = 0,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                stall,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                reg_write,
  input  logic                branch,
  input  logic                uncondbranch,
  input  logic                mem_ready,
  output logic                ir_load,
  output logic                rf_read_en,
  output logic                alu_en,
  output logic                mem_en,
  output logic                rf_write_en,
  output logic                pc_en,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    instr_count,
  output logic                busy,
  output logic                halted
);

  state_t r_state;
  state_t w_next_state;
  ctrl_t  r_ctl;

  logic w_ir_load;
  logic w_rf_read_en;
  logic w_alu_en;
  logic w_mem_en;
  logic w_rf_write_en;
  logic w_retire;
  logic w_limit_hit;
  logic w_unused_branch_kind;

  // Branch kinds need no extra stage; they retire straight out of EXECUTE.
  assign w_unused_branch_kind = r_ctl.branch ^ r_ctl.uncondbranch;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_DECODE && !stall)
      r_ctl <= '{mem_read: mem_read, mem_write: mem_write, reg_write: reg_write,
                 branch: branch, uncondbranch: uncondbranch};
  end

  always_comb begin
    w_next_state  = r_state;
    w_ir_load     = 1'b0;
    w_rf_read_en  = 1'b0;
    w_alu_en      = 1'b0;
    w_mem_en      = 1'b0;
    w_rf_write_en = 1'b0;
    w_retire      = 1'b0;
    if (!stall) begin
      case (r_state)
        ST_IDLE: begin
          if (run) w_next_state = ST_FETCH;
        end
        ST_FETCH: begin
          w_ir_load    = 1'b1;
          w_next_state = ST_DECODE;
        end
        ST_DECODE: begin
          w_rf_read_en = 1'b1;
          w_next_state = (opcode == HALT_OPCODE) ? ST_HALT : ST_EXECUTE;
        end
        ST_EXECUTE: begin
          w_alu_en = 1'b1;
          if (r_ctl.mem_read || r_ctl.mem_write) w_next_state = ST_MEMORY;
          else if (r_ctl.reg_write)              w_next_state = ST_WRITEBACK;
          else                                   w_retire     = 1'b1;
        end
        ST_MEMORY: begin
          w_mem_en = 1'b1;
          if (mem_ready) begin
            if (r_ctl.mem_read) w_next_state = ST_WRITEBACK;
            else                w_retire     = 1'b1;
          end
        end
        ST_WRITEBACK: begin
          w_rf_write_en = 1'b1;
          w_retire      = 1'b1;
        end
        ST_HALT: begin
          w_next_state = ST_HALT;
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
      // The retire limit outranks a pending run request.
      if (w_retire) begin
        if (w_limit_hit) w_next_state = ST_HALT;
        else if (run)    w_next_state = ST_FETCH;
        else             w_next_state = ST_IDLE;
      end
    end
  end

  retire_counter #(
    .CNT_W (CNT_W),
    .LIMIT (MAX_INSTR)
  ) u_retire_counter (
    .clk         (clk),
    .i_clr       (reset),
    .i_en        (w_retire),
    .o_count     (instr_count),
    .o_limit_hit (w_limit_hit)
  );

  assign ir_load     = w_ir_load;
  assign rf_read_en  = w_rf_read_en;
  assign alu_en      = w_alu_en;
  assign mem_en      = w_mem_en;
  assign rf_write_en = w_rf_write_en;
  assign pc_en       = w_retire;
  assign state       = r_state;
  assign busy        = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign halted      = (r_state == ST_HALT);

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: instruction-level phase model with random stalls,
// waits and don't-care inputs; three instances cover unlimited, limit and saturation.
module tb_stage_sequencer;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam int K_LDUR = 0, K_STUR = 1, K_ADD = 2, K_SUB = 3, K_CBZ = 4, K_B = 5;

  logic clk = 1'b0;
  logic reset, run, stall, mem_ready;
  logic mem_read, mem_write, reg_write, branch, uncondbranch;
  logic [10:0] opcode;

  logic d_ir, d_rd, d_alu, d_mem, d_wr, d_pc, d_busy, d_halted;
  logic [2:0] d_state;
  logic [31:0] d_count;
  logic l_ir, l_rd, l_alu, l_mem, l_wr, l_pc, l_busy, l_halted;
  logic [2:0] l_state;
  logic [31:0] l_count;
  logic s_ir, s_rd, s_alu, s_mem, s_wr, s_pc, s_busy, s_halted;
  logic [2:0] s_state;
  logic [1:0] s_count;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned exp_count = 0;

  always #5 clk = ~clk;

  stage_sequencer #(.CNT_W(32), .MAX_INSTR(0)) dut (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .opcode(opcode),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .branch(branch), .uncondbranch(uncondbranch), .mem_ready(mem_ready),
    .ir_load(d_ir), .rf_read_en(d_rd), .alu_en(d_alu), .mem_en(d_mem),
    .rf_write_en(d_wr), .pc_en(d_pc), .state(d_state), .instr_count(d_count),
    .busy(d_busy), .halted(d_halted));

  stage_sequencer #(.CNT_W(32), .MAX_INSTR(2)) dut_lim (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .opcode(opcode),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .branch(branch), .uncondbranch(uncondbranch), .mem_ready(mem_ready),
    .ir_load(l_ir), .rf_read_en(l_rd), .alu_en(l_alu), .mem_en(l_mem),
    .rf_write_en(l_wr), .pc_en(l_pc), .state(l_state), .instr_count(l_count),
    .busy(l_busy), .halted(l_halted));

  stage_sequencer #(.CNT_W(2), .MAX_INSTR(0)) dut_sat (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .opcode(opcode),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .branch(branch), .uncondbranch(uncondbranch), .mem_ready(mem_ready),
    .ir_load(s_ir), .rf_read_en(s_rd), .alu_en(s_alu), .mem_en(s_mem),
    .rf_write_en(s_wr), .pc_en(s_pc), .state(s_state), .instr_count(s_count),
    .busy(s_busy), .halted(s_halted));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe vector order: {ir_load, rf_read_en, alu_en, mem_en, rf_write_en, pc_en}
  function automatic logic [5:0] strobe_of(input int ph);
    case (ph)
      1:       return 6'b100000;
      2:       return 6'b010000;
      3:       return 6'b001000;
      4:       return 6'b000100;
      5:       return 6'b000010;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic garbage();
    opcode = 11'($urandom);
    {mem_read, mem_write, reg_write, branch, uncondbranch} = 5'($urandom);
  endtask

  // Check the current cycle against the model, then advance one clock.
  task automatic tick(input string tag, input int est, input logic [5:0] estb);
    logic [1:0] e_bh;
    int unsigned e_sat;
    #1;
    e_bh  = {(est >= 1 && est <= 5), (est == 6)};
    e_sat = (exp_count > 3) ? 3 : exp_count;
    chk({tag, " state"}, 32'(d_state), 32'(est));
    chk({tag, " strobes"}, 32'({d_ir, d_rd, d_alu, d_mem, d_wr, d_pc}), 32'(estb));
    chk({tag, " count"}, d_count, exp_count);
    chk({tag, " sat_count"}, 32'(s_count), e_sat);
    chk({tag, " busy_halted"}, 32'({d_busy, d_halted}), 32'(e_bh));
    @(posedge clk);
    if (estb[0]) exp_count++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b1; stall = 1'b0; mem_ready = 1'b0;
    garbage();
    @(posedge clk);
    exp_count = 0;
    @(negedge clk);
    repeat (2) begin
      garbage();
      tick("reset", 0, 6'b0);
    end
    #1;
    chk("reset lim_state", 32'(l_state), 32'd0);
    chk("reset lim_count", l_count, 32'd0);
    reset = 1'b0;
  endtask

  task automatic idle();
    stall = 1'b0; run = 1'b0; mem_ready = 1'($urandom);
    garbage();
    tick("idle", 0, 6'b0);
  endtask

  task automatic start();
    stall = 1'b0; run = 1'b1; mem_ready = 1'($urandom);
    garbage();
    tick("start", 0, 6'b0);
  endtask

  // Run one instruction from FETCH to retire. dphase/dn force dn stall cycles
  // ahead of that phase; pct adds random stalls on every phase.
  task automatic do_instr(input int kind, input int waitn, input int pct,
                          input int dphase, input int dn, input bit run_last);
    int phases[$];
    logic [4:0]  ctl;
    logic [10:0] opc;
    case (kind)
      K_LDUR:  begin opc = OP_LDUR; ctl = 5'b10100; end
      K_STUR:  begin opc = OP_STUR; ctl = 5'b01000; end
      K_ADD:   begin opc = OP_ADD;  ctl = 5'b00100; end
      K_SUB:   begin opc = OP_SUB;  ctl = 5'b00100; end
      K_CBZ:   begin opc = OP_CBZ;  ctl = 5'b00010; end
      default: begin opc = OP_B;    ctl = 5'b00001; end
    endcase
    phases = '{1, 2, 3};
    if (ctl[4] || ctl[3]) begin
      repeat (waitn + 1) phases.push_back(4);
      if (ctl[4]) phases.push_back(5);
    end else if (ctl[2]) begin
      phases.push_back(5);
    end
    foreach (phases[p]) begin
      int ph;
      int ns;
      bit last;
      ph   = phases[p];
      last = (p == phases.size() - 1);
      ns   = (ph == dphase) ? dn : 0;
      while (pct > 0 && ns < 4 && $urandom_range(0, 99) < pct) ns++;
      repeat (ns) begin
        stall = 1'b1; run = 1'($urandom); mem_ready = 1'($urandom);
        garbage();
        tick("stalled", ph, 6'b0);
      end
      stall = 1'b0;
      garbage();
      if (ph == 2) begin
        opcode = opc;
        {mem_read, mem_write, reg_write, branch, uncondbranch} = ctl;
      end
      if (ph == 4) mem_ready = last ? 1'b1 : (phases[p+1] != 4);
      else         mem_ready = 1'($urandom);
      run = last ? run_last : 1'($urandom);
      tick("instr", ph, strobe_of(ph) | (last ? 6'b000001 : 6'b0));
    end
  endtask

  task automatic do_halt();
    stall = 1'b0; run = 1'($urandom); mem_ready = 1'($urandom);
    garbage();
    tick("halt fetch", 1, strobe_of(1));
    garbage();
    opcode = 11'b00000000000;
    tick("halt decode", 2, strobe_of(2));
    repeat (10) begin
      stall = 1'($urandom); run = 1'($urandom); mem_ready = 1'($urandom);
      garbage();
      tick("halted", 6, 6'b0);
    end
  endtask

  initial begin
    int kind, w;
    bit rl;
    reset = 1'b1; run = 1'b0; stall = 1'b0; mem_ready = 1'b0;
    opcode = '0;
    {mem_read, mem_write, reg_write, branch, uncondbranch} = '0;

    do_reset();
    idle();

    // LDUR with one wait cycle, then ADD and CBZ back to back, then stop.
    start();
    do_instr(K_LDUR, 1, 0, 0, 0, 1'b1);
    do_instr(K_ADD, 0, 0, 0, 0, 1'b1);
    do_instr(K_CBZ, 0, 0, 0, 0, 1'b0);
    idle();

    // SUB with three stall cycles on EXECUTE.
    start();
    do_instr(K_SUB, 0, 0, 3, 3, 1'b0);
    idle();

    // Random instruction mix with random stalls and memory waits.
    start();
    repeat (40) begin
      kind = $urandom_range(0, 5);
      w    = $urandom_range(0, 3);
      rl   = 1'($urandom_range(0, 1));
      do_instr(kind, w, 25, 0, 0, rl);
      if (!rl) begin
        idle();
        start();
      end
    end
    do_instr(K_STUR, 2, 0, 0, 0, 1'b1);

    // Halt opcode is absorbing.
    do_halt();

    // Reset while STUR waits in MEMORY.
    do_reset();
    start();
    do_instr(K_ADD, 0, 0, 0, 0, 1'b1);
    stall = 1'b0; run = 1'b1; mem_ready = 1'b0;
    garbage();
    tick("stur fetch", 1, strobe_of(1));
    garbage();
    opcode = OP_STUR;
    {mem_read, mem_write, reg_write, branch, uncondbranch} = 5'b01000;
    tick("stur decode", 2, strobe_of(2));
    garbage();
    tick("stur execute", 3, strobe_of(3));
    garbage();
    mem_ready = 1'b0;
    tick("stur memory", 4, strobe_of(4));
    garbage();
    reset = 1'b1; mem_ready = 1'b0;
    tick("stur reset", 4, strobe_of(4));
    exp_count = 0;
    reset = 1'b0;
    idle();

    // Retire limit of 2 on dut_lim with run held high.
    do_reset();
    start();
    do_instr(K_ADD, 0, 0, 0, 0, 1'b1);
    #1;
    chk("lim count1", l_count, 32'd1);
    chk("lim state1", 32'(l_state), 32'd1);
    do_instr(K_CBZ, 0, 0, 0, 0, 1'b1);
    #1;
    chk("lim state2", 32'(l_state), 32'd6);
    chk("lim halted2", 32'({l_busy, l_halted}), 32'b01);
    chk("lim count2", l_count, 32'd2);
    do_instr(K_B, 0, 0, 0, 0, 1'b0);
    #1;
    chk("lim state3", 32'(l_state), 32'd6);
    chk("lim strobes3", 32'({l_ir, l_rd, l_alu, l_mem, l_wr, l_pc}), 32'd0);
    chk("lim count3", l_count, 32'd2);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
